// File: rtl/pic_inta_sequencer_if.sv
// PIC INTA sequencer bus bundle.
// Resolver inputs, CPU handshake, EOI commands and vector outputs.
interface pic_inta_sequencer_if;
  logic       start_interrupt_flag;
  logic [2:0] highest_priority_id;
  logic       inta_n;
  logic [4:0] vector_base;
  logic       aeoi_mode;
  logic       eoi_valid;
  logic       eoi_specific;
  logic [2:0] eoi_level;
  logic       int_out;
  logic [7:0] isr;
  logic [7:0] irr_clear;
  logic [7:0] data_out;
  logic       data_out_en;

  modport master (
    output start_interrupt_flag,
    output highest_priority_id,
    output inta_n,
    output vector_base,
    output aeoi_mode,
    output eoi_valid,
    output eoi_specific,
    output eoi_level,
    input  int_out,
    input  isr,
    input  irr_clear,
    input  data_out,
    input  data_out_en
  );

  modport slave (
    input  start_interrupt_flag,
    input  highest_priority_id,
    input  inta_n,
    input  vector_base,
    input  aeoi_mode,
    input  eoi_valid,
    input  eoi_specific,
    input  eoi_level,
    output int_out,
    output isr,
    output irr_clear,
    output data_out,
    output data_out_en
  );
endinterface

// File: rtl/pic_inta_sequencer.sv
// PIC INT/INTA sequencer: 8086-mode two-pulse acknowledge,
// in-service register, IRR clear pulses, vector drive and EOI.
module pic_inta_sequencer (
  input logic            clk,
  input logic            reset,
  pic_inta_sequencer_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_PEND,
    S_ACK1,
    S_VEC
  } state_t;

  state_t     state_q;
  state_t     state_d;
  logic       inta_q;
  logic       inta_d;
  logic [2:0] ack_id_q;
  logic [2:0] ack_id_d;
  logic       spur_q;
  logic       spur_d;
  logic       int_out_q;
  logic       int_out_d;
  logic [7:0] isr_q;
  logic [7:0] isr_d;
  logic [7:0] irr_clear_q;
  logic [7:0] irr_clear_d;
  logic [7:0] data_out_q;
  logic [7:0] data_out_d;
  logic       data_out_en_q;
  logic       data_out_en_d;

  logic       fall;
  logic       rise;
  logic [7:0] set_mask;
  logic [7:0] aeoi_mask;
  logic [7:0] eoi_mask;

  assign inta_d = bus.inta_n;
  assign fall   = inta_q & ~bus.inta_n;
  assign rise   = ~inta_q & bus.inta_n;

  // EOI clear mask; non-specific picks the lowest set bit (IR0 highest)
  always_comb begin
    eoi_mask = '0;
    if (bus.eoi_valid) begin
      if (bus.eoi_specific) begin
        eoi_mask[bus.eoi_level] = 1'b1;
      end else begin
        eoi_mask = isr_q & (~isr_q + 8'd1);
      end
    end
  end

  // Handshake FSM next-state, outputs and ISR update
  always_comb begin
    state_d       = state_q;
    ack_id_d      = ack_id_q;
    spur_d        = spur_q;
    int_out_d     = int_out_q;
    data_out_d    = data_out_q;
    data_out_en_d = data_out_en_q;
    irr_clear_d   = '0;
    set_mask      = '0;
    aeoi_mask     = '0;
    unique case (state_q)
      S_IDLE: begin
        if (bus.start_interrupt_flag) begin
          state_d   = S_PEND;
          int_out_d = 1'b1;
        end
      end
      S_PEND: begin
        if (fall) begin
          state_d = S_ACK1;
          if (bus.start_interrupt_flag) begin
            ack_id_d = bus.highest_priority_id;
            spur_d   = 1'b0;
            set_mask[bus.highest_priority_id]    = 1'b1;
            irr_clear_d[bus.highest_priority_id] = 1'b1;
          end else begin
            ack_id_d = 3'd7;
            spur_d   = 1'b1;
          end
        end
      end
      S_ACK1: begin
        if (fall) begin
          state_d       = S_VEC;
          int_out_d     = 1'b0;
          data_out_d    = {bus.vector_base, ack_id_q};
          data_out_en_d = 1'b1;
        end
      end
      S_VEC: begin
        if (rise) begin
          state_d       = S_IDLE;
          data_out_en_d = 1'b0;
          data_out_d    = '0;
          if (bus.aeoi_mode && !spur_q) begin
            aeoi_mask[ack_id_q] = 1'b1;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    isr_d = (isr_q & ~(eoi_mask | aeoi_mask)) | set_mask;
  end

  // State and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= S_IDLE;
      inta_q        <= 1'b1;
      ack_id_q      <= '0;
      spur_q        <= 1'b0;
      int_out_q     <= 1'b0;
      isr_q         <= '0;
      irr_clear_q   <= '0;
      data_out_q    <= '0;
      data_out_en_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      inta_q        <= inta_d;
      ack_id_q      <= ack_id_d;
      spur_q        <= spur_d;
      int_out_q     <= int_out_d;
      isr_q         <= isr_d;
      irr_clear_q   <= irr_clear_d;
      data_out_q    <= data_out_d;
      data_out_en_q <= data_out_en_d;
    end
  end

  assign bus.int_out     = int_out_q;
  assign bus.isr         = isr_q;
  assign bus.irr_clear   = irr_clear_q;
  assign bus.data_out    = data_out_q;
  assign bus.data_out_en = data_out_en_q;

endmodule
